// File: rtl/accel_spi_avg_if.sv
// Pin-level and result bundle for the accelerometer SPI master.
// The master side is the SPI controller; the slave side is the device plus the consumer of out_data.
interface accel_spi_avg_if #(
    parameter int NUM_AXES = 3
);
    logic                      sdi;
    logic                      sdo;
    logic                      cs_n;
    logic                      sclk;
    logic [16*NUM_AXES-1:0]    out_data;
    logic                      out_valid;
    logic                      init_done;

    modport master (
        input  sdi,
        output sdo, cs_n, sclk, out_data, out_valid, init_done
    );

    modport slave (
        output sdi,
        input  sdo, cs_n, sclk, out_data, out_valid, init_done
    );
endinterface

// File: rtl/accel_spi_avg.sv
// SPI mode-3 master for a 3-axis accelerometer: two init writes, then periodic
// burst reads, each axis run through a signed moving-average filter.
module accel_spi_avg #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCLK_HZ      = 2_000_000,
    parameter int SAMPLE_HZ    = 3200,
    parameter int FILTER_SHIFT = 2,
    parameter int NUM_AXES     = 3
) (
    input  logic            clk,
    input  logic            rst,
    accel_spi_avg_if.master bus
);
    localparam int HALF_RAW = CLK_HZ / (2 * SCLK_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int PERIOD   = CLK_HZ / SAMPLE_HZ;
    localparam int RXW      = 16 * NUM_AXES;
    localparam int RD_BITS  = 8 + RXW;
    localparam int DEPTH    = 1 << FILTER_SHIFT;
    localparam int SW       = 16 + FILTER_SHIFT;
    localparam int HW       = $clog2(2 * HALF + 1);
    localparam int BW       = $clog2(RD_BITS + 1);
    localparam int TW       = $clog2(PERIOD + 1);
    localparam int PW       = (FILTER_SHIFT > 0) ? FILTER_SHIFT : 1;
    localparam int FW       = FILTER_SHIFT + 1;

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_e;

    state_e         state_q, state_d;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic [15:0]    tx_q, tx_d;
    logic [RXW-1:0] rx_q, rx_d;
    logic           sclk_q, sclk_d, cs_n_q, cs_n_d, sdo_q, sdo_d;
    logic [1:0]     init_q, init_d;
    logic           rd_q, rd_d, pend_q, pend_d;
    logic [TW-1:0]  tmr_q;
    logic           tick, cap, init_done, filled, out_valid_q;
    logic [1:0]     vld_pipe_q;
    logic [PW-1:0]  ptr_q;
    logic [FW-1:0]  fill_q;
    logic [RXW-1:0] out_data;

    assign tick      = (tmr_q == TW'(PERIOD - 1));
    assign init_done = (init_q == 2'd2);
    assign filled    = (fill_q == FW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) tmr_q <= '0;
        else     tmr_q <= tick ? '0 : tmr_q + TW'(1);
    end

    // sclk_q doubles as the bit phase inside SHIFT: low half then high half.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        sdo_d   = sdo_q;
        init_d  = init_q;
        rd_d    = rd_q;
        pend_d  = pend_q | tick;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!init_done || pend_q) begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                    hcnt_d  = '0;
                    pend_d  = 1'b0;
                    rd_d    = init_done;
                    tx_d    = init_done ? 16'hF200 : ((init_q == 2'd0) ? 16'h3100 : 16'h2C0F);
                    bcnt_d  = init_done ? BW'(RD_BITS) : BW'(16);
                end
            end
            CS_SETUP: begin
                if (hcnt_q == HW'(HALF - 1)) begin
                    state_d = SHIFT;
                    hcnt_d  = '0;
                    sclk_d  = 1'b0;
                    sdo_d   = tx_q[15];
                    tx_d    = {tx_q[14:0], 1'b0};
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            SHIFT: begin
                if (hcnt_q != HW'(HALF - 1)) begin
                    hcnt_d = hcnt_q + HW'(1);
                end else begin
                    hcnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[RXW-2:0], bus.sdi};
                        bcnt_d = bcnt_q - BW'(1);
                    end else if (bcnt_q == '0) begin
                        state_d = CS_HOLD;
                        sdo_d   = 1'b0;
                    end else begin
                        sclk_d = 1'b0;
                        sdo_d  = tx_q[15];
                        tx_d   = {tx_q[14:0], 1'b0};
                    end
                end
            end
            CS_HOLD: begin
                if (hcnt_q == HW'(HALF - 1)) begin
                    state_d = GAP;
                    hcnt_d  = '0;
                    cs_n_d  = 1'b1;
                    if (rd_q) cap = 1'b1;
                    else      init_d = init_q + 2'd1;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            GAP: begin
                if (hcnt_q == HW'(2 * HALF - 1)) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            sdo_q   <= 1'b0;
            init_q  <= '0;
            rd_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            sdo_q   <= sdo_d;
            init_q  <= init_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
        end
    end

    // Capture at T, filter update at T+1, output register at T+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            ptr_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[0], cap};
            out_valid_q <= vld_pipe_q[1] && filled;
            if (vld_pipe_q[0]) begin
                ptr_q <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
                if (!filled) fill_q <= fill_q + FW'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_AXES; k++) begin : g_axis
        localparam int HI = RXW - 1 - 16 * k;
        logic signed [15:0]   smp_q, out_q;
        logic signed [15:0]   hist_q [DEPTH];
        logic signed [SW-1:0] sum_q;

        // Device sends each axis low byte first.
        always_ff @(posedge clk) begin
            if (rst) begin
                smp_q <= '0;
                sum_q <= '0;
                out_q <= '0;
                for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
            end else begin
                if (cap) smp_q <= {rx_q[HI-8 -: 8], rx_q[HI -: 8]};
                if (vld_pipe_q[0]) begin
                    sum_q          <= sum_q + SW'(smp_q) - SW'(hist_q[ptr_q]);
                    hist_q[ptr_q]  <= smp_q;
                end
                if (vld_pipe_q[1] && filled) out_q <= 16'(sum_q >>> FILTER_SHIFT);
            end
        end

        assign out_data[16*k +: 16] = out_q;
    end

    assign bus.sdo       = sdo_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.sclk      = sclk_q;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid_q;
    assign bus.init_done = init_done;
endmodule

// File: tb/tb_accel_spi_avg.sv
// Directed bench for accel_spi_avg: accelerometer pin model, window-average
// reference model and an output scoreboard.
module tb_accel_spi_avg;
    localparam int CLK_HZ       = 1_000_000;
    localparam int SCLK_HZ      = 250_000;
    localparam int SAMPLE_HZ    = 1000;
    localparam int FILTER_SHIFT = 2;
    localparam int NUM_AXES     = 3;
    localparam int HALF         = 2;
    localparam int PERIOD       = 1000;
    localparam int TCLK         = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accel_spi_avg_if #(.NUM_AXES(NUM_AXES)) bus ();

    accel_spi_avg #(
        .CLK_HZ(CLK_HZ), .SCLK_HZ(SCLK_HZ), .SAMPLE_HZ(SAMPLE_HZ),
        .FILTER_SHIFT(FILTER_SHIFT), .NUM_AXES(NUM_AXES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Accelerometer: latches its reply at cs_n fall, drives sdi on sclk fall,
    // samples sdo on sclk rise.
    logic        sdi_r = 1'b0;
    logic [15:0] dev_x = '0, dev_y = '0, dev_z = '0;
    logic [55:0] resp = '0;
    int          rd_idx = 0;
    logic [63:0] mosi_sr = '0;
    int          mosi_bits = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1;

    assign bus.sdi = sdi_r;

    always @(bus.cs_n or bus.sclk) begin
        if (prev_cs === 1'b1 && bus.cs_n === 1'b0) begin
            resp      = {8'h00, dev_x[7:0], dev_x[15:8], dev_y[7:0], dev_y[15:8], dev_z[7:0], dev_z[15:8]};
            rd_idx    = 0;
            mosi_sr   = '0;
            mosi_bits = 0;
        end
        if (bus.cs_n === 1'b0 && prev_sclk === 1'b1 && bus.sclk === 1'b0) begin
            if (rd_idx < 56) sdi_r = resp[55-rd_idx];
            rd_idx++;
        end
        if (bus.cs_n === 1'b0 && prev_sclk === 1'b0 && bus.sclk === 1'b1) begin
            mosi_sr = {mosi_sr[62:0], bus.sdo};
            mosi_bits++;
        end
        prev_cs   = bus.cs_n;
        prev_sclk = bus.sclk;
    end

    logic [47:0]        exp_q[$];
    logic [47:0]        last_out = '0;
    logic signed [15:0] hist [3][4];
    int                 nfill = 0;
    time                rise_main = 0, prev_fall = 0;
    bit                 have_prev = 1'b0;

    task automatic model_clear();
        nfill = 0;
        for (int a = 0; a < 3; a++)
            for (int i = 0; i < 4; i++) hist[a][i] = '0;
    endtask

    // Reference: plain sum over the last four samples, floored divide by 4.
    task automatic model_push(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        logic [15:0] s [3];
        logic [47:0] e;
        int acc;
        s[0] = x; s[1] = y; s[2] = z;
        e = '0;
        for (int a = 0; a < 3; a++) begin
            for (int i = 3; i > 0; i--) hist[a][i] = hist[a][i-1];
            hist[a][0] = s[a];
        end
        nfill++;
        if (nfill >= 4) begin
            for (int a = 0; a < 3; a++) begin
                acc = 0;
                for (int i = 0; i < 4; i++) acc += int'(hist[a][i]);
                e[16*a +: 16] = 16'(acc >>> 2);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        logic prev = 1'b1;
        time rt = 0;
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (prev === 1'b0 && bus.cs_n === 1'b1) rt = $time;
            prev = bus.cs_n;
            if (bus.out_valid === 1'b1) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++; $error("FAIL sb_unexpected_valid got=%h want=no_output", bus.out_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    total++;
                    assert (bus.out_data === e) else begin
                        bad++; $error("FAIL sb_out_data got=%h want=%h", bus.out_data, e);
                    end
                    total++;
                    assert ($time - rt == 2 * TCLK) else begin
                        bad++; $error("FAIL latency got=%0t want=%0d", $time - rt, 2 * TCLK);
                    end
                end
                last_out = bus.out_data;
            end
        end
    endtask

    task automatic wait_cs(input logic lvl, input string tag);
        int n = 0;
        while (bus.cs_n !== lvl && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (bus.cs_n === lvl) else begin
            bad++; $error("FAIL %s_timeout got=%b want=%b", tag, bus.cs_n, lvl);
        end
    endtask

    task automatic init_frame(input logic [15:0] val, input logic want_done, input bit chk_gap, input string tag);
        time tf;
        wait_cs(1'b0, tag);
        tf = $time;
        if (chk_gap) begin
            total++;
            assert (tf - rise_main >= 2 * HALF * TCLK) else begin
                bad++; $error("FAIL %s_gap got=%0t want>=%0d", tag, tf - rise_main, 2 * HALF * TCLK);
            end
        end
        wait_cs(1'b1, tag);
        rise_main = $time;
        total++;
        assert (mosi_bits == 16 && mosi_sr[15:0] === val) else begin
            bad++; $error("FAIL %s_word got=%0d/%h want=16/%h", tag, mosi_bits, mosi_sr[15:0], val);
        end
        total++;
        assert (bus.init_done === want_done) else begin
            bad++; $error("FAIL %s_init_done got=%b want=%b", tag, bus.init_done, want_done);
        end
    endtask

    task automatic rd_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        dev_x = x; dev_y = y; dev_z = z;
        model_push(x, y, z);
        wait_cs(1'b0, "rd_fall");
        if (have_prev) begin
            total++;
            assert ($time - prev_fall == PERIOD * TCLK) else begin
                bad++; $error("FAIL rd_spacing got=%0t want=%0d", $time - prev_fall, PERIOD * TCLK);
            end
        end
        prev_fall = $time;
        have_prev = 1'b1;
        wait_cs(1'b1, "rd_rise");
        rise_main = $time;
        total++;
        assert (mosi_bits == 56 && mosi_sr[55:0] === {8'hF2, 48'h0}) else begin
            bad++; $error("FAIL rd_cmd got=%0d/%h want=56/%h", mosi_bits, mosi_sr[55:0], {8'hF2, 48'h0});
        end
    endtask

    task automatic chk_out(input logic [47:0] want, input string tag);
        repeat (4) @(negedge clk);
        total++;
        assert (last_out === want) else begin
            bad++; $error("FAIL %s got=%h want=%h", tag, last_out, want);
        end
    endtask

    initial begin
        int n;
        model_clear();
        fork
            monitor();
        join_none

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        assert (bus.cs_n === 1'b1 && bus.sclk === 1'b1 && bus.sdo === 1'b0) else begin
            bad++; $error("FAIL reset_pins got=%b%b%b want=110", bus.cs_n, bus.sclk, bus.sdo);
        end
        total++;
        assert (bus.out_valid === 1'b0 && bus.out_data === 48'h0 && bus.init_done === 1'b0) else begin
            bad++; $error("FAIL reset_out got=%b/%h/%b want=0/0/0", bus.out_valid, bus.out_data, bus.init_done);
        end
        rst = 1'b0;

        // Init sequence
        init_frame(16'h3100, 1'b0, 1'b0, "init0");
        init_frame(16'h2C0F, 1'b1, 1'b1, "init1");

        // Constant device values: output only from the fourth frame
        for (int i = 0; i < 4; i++) rd_frame(16'h0100, 16'hFF00, 16'h0004);
        chk_out({16'h0004, 16'hFF00, 16'h0100}, "const_avg");

        // Signed averages
        rd_frame(16'hFFFF, 16'h1111, 16'hEEEE);
        for (int i = 0; i < 3; i++) rd_frame(16'h0000, 16'h1111, 16'hEEEE);
        chk_out({16'hEEEE, 16'h1111, 16'hFFFF}, "neg_floor");
        for (int i = 0; i < 4; i++) rd_frame(16'h8000, 16'h7FFF, 16'h0000);
        chk_out({16'h0000, 16'h7FFF, 16'h8000}, "min_val");
        for (int i = 0; i < 4; i++) rd_frame(16'h7FFF, 16'h8000, 16'hFFFF);
        chk_out({16'hFFFF, 16'h8000, 16'h7FFF}, "max_val");

        // Ring wrap
        for (int i = 1; i <= 3; i++) rd_frame(16'(i), 16'h0000, 16'h0000);
        rd_frame(16'd4, 16'h0000, 16'h0000);
        chk_out({32'h0, 16'd2}, "wrap4");
        rd_frame(16'd5, 16'h0000, 16'h0000);
        chk_out({32'h0, 16'd3}, "wrap5");
        rd_frame(16'd6, 16'h0000, 16'h0000);
        chk_out({32'h0, 16'd4}, "wrap6");

        // Reset in the middle of a read frame
        dev_x = 16'h0040; dev_y = 16'h0040; dev_z = 16'h0040;
        wait_cs(1'b0, "mid_fall");
        n = 0;
        while (mosi_bits < 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (mosi_bits == 20) else begin
            bad++; $error("FAIL mid_bit got=%0d want=20", mosi_bits);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        assert (bus.cs_n === 1'b1 && bus.sclk === 1'b1 && bus.init_done === 1'b0 && bus.out_valid === 1'b0) else begin
            bad++; $error("FAIL mid_reset got=%b%b%b%b want=1100", bus.cs_n, bus.sclk, bus.init_done, bus.out_valid);
        end
        rst = 1'b0;
        have_prev = 1'b0;
        model_clear();
        init_frame(16'h3100, 1'b0, 1'b0, "reinit0");
        init_frame(16'h2C0F, 1'b1, 1'b1, "reinit1");
        for (int i = 0; i < 4; i++) rd_frame(16'h0123, 16'hFEDC, 16'h8001);
        chk_out({16'h8001, 16'hFEDC, 16'h0123}, "refill");

        repeat (10) @(negedge clk);
        total++;
        assert (exp_q.size() == 0) else begin
            bad++; $error("FAIL sb_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
